// File: rtl/parking_pkg.sv
// parking_pkg: shared gate-state enums and time-of-day widths for the parking controller
package parking_pkg;
  localparam int HOUR_W       = 6;
  localparam int MIN_W        = 6;
  localparam int DAY_HOURS    = 24;
  localparam int HOUR_MINUTES = 60;
  typedef enum logic [1:0] {E_IDLE, E_CHECK, E_OPEN, E_DENY} entry_state_e;
  typedef enum logic {X_IDLE, X_OPEN} exit_state_e;
endpackage

// File: rtl/parking_clock.sv
// parking_clock: tick/minute/hour time-of-day counter
module parking_clock
  import parking_pkg::*;
#(
  parameter int TICKS_PER_MIN = 60,
  parameter int START_HOUR    = 8
) (
  input  logic              clk,
  input  logic              rst,
  output logic [HOUR_W-1:0] hour_o,
  output logic [MIN_W-1:0]  minute_o
);
  localparam int TW = $clog2(TICKS_PER_MIN + 1);
  logic [TW-1:0] tick_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_q   <= '0;
      minute_o <= '0;
      hour_o   <= HOUR_W'(START_HOUR);
    end else if (tick_q == TW'(TICKS_PER_MIN - 1)) begin
      tick_q <= '0;
      if (minute_o == MIN_W'(HOUR_MINUTES - 1)) begin
        minute_o <= '0;
        hour_o   <= (hour_o == HOUR_W'(DAY_HOURS - 1)) ? '0 : hour_o + 1'b1;
      end else begin
        minute_o <= minute_o + 1'b1;
      end
    end else begin
      tick_q <= tick_q + 1'b1;
    end
  end
endmodule

// File: rtl/parking_gate_ctrl.sv
// parking_gate_ctrl: entry/exit gate sequencing, event serialisation and time of day
module parking_gate_ctrl
  import parking_pkg::*;
#(
  parameter int TICKS_PER_MIN = 60,
  parameter int HOLD_CYCLES   = 8,
  parameter int START_HOUR    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arrive_req,
  input  logic              arrive_uni,
  input  logic              pass_entry,
  input  logic              exit_req,
  input  logic              exit_uni,
  input  logic              pass_exit,
  input  logic              uni_is_vacated_space,
  input  logic              is_vacated_space,
  output logic              car_entered,
  output logic              is_uni_car_entered,
  output logic              car_exited,
  output logic              is_uni_car_exited,
  output logic [HOUR_W-1:0] current_hour,
  output logic [MIN_W-1:0]  current_minute,
  output logic              entry_open,
  output logic              exit_open,
  output logic              entry_denied
);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  entry_state_e  e_state_q;
  exit_state_e   x_state_q;
  logic          arr_q, exr_q, e_uni_q, x_uni_q, pend_q;
  logic [HW-1:0] e_cnt_q, x_cnt_q;
  logic          entry_ev, exit_ev, admit, entry_fire_d;
  assign entry_ev     = (e_state_q == E_OPEN) && pass_entry;
  assign exit_ev      = (x_state_q == X_OPEN) && pass_exit;
  assign admit        = e_uni_q ? uni_is_vacated_space : is_vacated_space;
  assign entry_fire_d = pend_q || (entry_ev && !exit_ev);
  parking_clock #(.TICKS_PER_MIN(TICKS_PER_MIN), .START_HOUR(START_HOUR)) u_clock (
    .clk      (clk),
    .rst      (rst),
    .hour_o   (current_hour),
    .minute_o (current_minute)
  );
  always_ff @(posedge clk) begin
    arr_q <= rst ? 1'b0 : arrive_req;
    exr_q <= rst ? 1'b0 : exit_req;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      e_state_q    <= E_IDLE;
      e_uni_q      <= 1'b0;
      e_cnt_q      <= '0;
      entry_open   <= 1'b0;
      entry_denied <= 1'b0;
    end else begin
      entry_denied <= 1'b0;
      case (e_state_q)
        E_IDLE: if (arrive_req && !arr_q) begin
          e_uni_q   <= arrive_uni;
          e_state_q <= E_CHECK;
        end
        E_CHECK: begin
          e_cnt_q      <= '0;
          e_state_q    <= admit ? E_OPEN : E_DENY;
          entry_open   <= admit;
          entry_denied <= !admit;
        end
        E_OPEN: if (pass_entry || e_cnt_q == HW'(HOLD_CYCLES - 1)) begin
          e_state_q  <= E_IDLE;
          entry_open <= 1'b0;
        end else begin
          e_cnt_q <= e_cnt_q + 1'b1;
        end
        E_DENY: if (!arrive_req) e_state_q <= E_IDLE;
        default: e_state_q <= E_IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      x_state_q <= X_IDLE;
      x_uni_q   <= 1'b0;
      x_cnt_q   <= '0;
      exit_open <= 1'b0;
    end else begin
      case (x_state_q)
        X_IDLE: if (exit_req && !exr_q) begin
          x_uni_q   <= exit_uni;
          x_cnt_q   <= '0;
          x_state_q <= X_OPEN;
          exit_open <= 1'b1;
        end
        X_OPEN: if (pass_exit || x_cnt_q == HW'(HOLD_CYCLES - 1)) begin
          x_state_q <= X_IDLE;
          exit_open <= 1'b0;
        end else begin
          x_cnt_q <= x_cnt_q + 1'b1;
        end
        default: x_state_q <= X_IDLE;
      endcase
    end
  end
  // exit wins a same-cycle collision; the entry event is replayed one cycle later
  always_ff @(posedge clk) begin
    if (rst) begin
      car_entered        <= 1'b0;
      is_uni_car_entered <= 1'b0;
      car_exited         <= 1'b0;
      is_uni_car_exited  <= 1'b0;
      pend_q             <= 1'b0;
    end else begin
      car_entered        <= entry_fire_d;
      is_uni_car_entered <= entry_fire_d && e_uni_q;
      car_exited         <= exit_ev;
      is_uni_car_exited  <= exit_ev && x_uni_q;
      pend_q             <= entry_ev && exit_ev;
    end
  end
endmodule

// File: doc/parking_gate_ctrl.md
# parking_gate_ctrl

Gate-side event generator for the parking controller. It sequences raw entry and exit lane sensors into the one-cycle `car_entered`, `car_exited` and `is_uni_*` event pulses that `parking` consumes. It also owns the time-of-day counter that drives `current_hour`. It uses `parking`'s vacancy outputs to decide whether an arriving car is admitted, and sits between the lane hardware and `parking`.

## Interface
Parameters:
- `TICKS_PER_MIN`, default 60: clock cycles per simulated minute.
- `HOLD_CYCLES`, default 8: cycles a barrier stays open waiting for the pass sensor.
- `START_HOUR`, default 8: hour loaded on reset (0–23).

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `arrive_req` in 1: car present at entry loop (level).
- `arrive_uni` in 1: uni badge valid; sampled with `arrive_req` rise.
- `pass_entry` in 1: car crossed entry barrier (pulse/level).
- `exit_req` in 1: car present at exit loop (level).
- `exit_uni` in 1: uni badge at exit; sampled with `exit_req` rise.
- `pass_exit` in 1: car crossed exit barrier.
- `uni_is_vacated_space` in 1: from `parking`.
- `is_vacated_space` in 1: from `parking`.
- `car_entered` out 1: one-cycle entry event.
- `is_uni_car_entered` out 1: valid with `car_entered`, else 0.
- `car_exited` out 1: one-cycle exit event.
- `is_uni_car_exited` out 1: valid with `car_exited`, else 0.
- `current_hour` out 6: 0–23.
- `current_minute` out 6: 0–59.
- `entry_open` out 1: entry barrier command.
- `exit_open` out 1: exit barrier command.
- `entry_denied` out 1: one-cycle pulse when admission is refused.

## Operation
- **Time of day:** tick counter 0..`TICKS_PER_MIN`-1. On wrap, minute increments. Minute 59→0 increments hour. Hour 23→0.
- **Entry FSM:** states `E_IDLE`, `E_CHECK`, `E_OPEN`, `E_DENY`.
  - `E_IDLE`: on rising edge of `arrive_req`, latch `arrive_uni` and go to `E_CHECK`.
  - `E_CHECK`: one cycle. Admit if the latched uni flag is 1 and `uni_is_vacated_space`=1, or the flag is 0 and `is_vacated_space`=1. Admit → `E_OPEN`. Otherwise pulse `entry_denied` and go to `E_DENY`.
  - `E_OPEN`: `entry_open`=1 and the hold counter runs. On `pass_entry`, raise an entry event and go to `E_IDLE`. If the counter reaches `HOLD_CYCLES` without a pass, go to `E_IDLE` with no event.
  - `E_DENY`: wait for `arrive_req`=0, then go to `E_IDLE`.
- **Exit FSM:** states `X_IDLE`, `X_OPEN`. Exit is always admitted.
  - `X_IDLE`: on rising edge of `exit_req`, latch `exit_uni` and go to `X_OPEN`.
  - `X_OPEN`: on `pass_exit`, raise an exit event. A timeout after `HOLD_CYCLES` closes the barrier with no event.
- **Event serialisation:**
  - Entry and exit pulses never assert in the same cycle.
  - If both are raised in the same cycle, the exit pulse goes out that cycle and the entry event is held in `pend_entry`, pulsing the next cycle.
  - `pend_entry` holds one event only. A new entry cannot be raised while it is set, because the FSM is already back in `E_IDLE` and needs a fresh arrive rise plus `E_CHECK` first.
- Pass sensors outside `E_OPEN` / `X_OPEN` are ignored.

## Timing
- **Reset values:** all event outputs, `entry_open`, `exit_open` and `entry_denied` = 0. `current_hour`=`START_HOUR`, `current_minute`=0, tick counter 0, FSMs in `*_IDLE`, `pend_entry`=0.
- Reset asserted mid-operation aborts any open gate next edge with no event emitted. A pending entry is dropped.
- **Entry latency:** `arrive_req` rise sampled at edge n → `E_CHECK` after n → `entry_open`=1 after edge n+1.
- **Deny latency:** `entry_denied` is high in the cycle after edge n+1.
- **Pass to event:** `pass_entry` / `pass_exit` sampled at edge m → event pulse high after edge m, for exactly one cycle (plus one cycle of delay for a deferred entry). The barrier output drops on the same edge.
- **Timeout:** barrier high for exactly `HOLD_CYCLES` cycles.
- **Vacancy sampling:** vacancy inputs are sampled only in `E_CHECK`.
- **Output registers:** all outputs are registered; no combinational paths from inputs to outputs.

## Structure
- **Shared package `parking_pkg`:** entry and exit state enums, `HOUR_W`=6, `MIN_W`=6, `DAY_HOURS`=24, `HOUR_MINUTES`=60.
- **Sub-module `parking_clock`:** tick, minute and hour counter, with `START_HOUR` and `TICKS_PER_MIN` parameters.
- Gate FSMs, hold counters and the serialiser live in the top module.

## Test plan
- **Reset and clock rollover:** `TICKS_PER_MIN`=2, `START_HOUR`=23, run 120 cycles → hour wraps 23→0 at minute 59→0. `current_minute`=0 after wrap.
- **Uni admit:** `arrive_req` and `arrive_uni`=1, `uni_is_vacated_space`=1, then `pass_entry` 3 cycles later → `entry_open` high, one-cycle `car_entered`=1 with `is_uni_car_entered`=1.
- **Deny:** non-uni arrival with `is_vacated_space`=0 → `entry_denied` single pulse, `entry_open` stays 0. No new check until `arrive_req` drops and rises again.
- **Timeout:** `HOLD_CYCLES`=8, admitted car never passes → `entry_open` high exactly 8 cycles, no `car_entered`.
- **Simultaneous events:** `pass_entry` and `pass_exit` on the same edge → `car_exited` in cycle k, `car_entered` in cycle k+1, never overlapping.
- **Reset mid-open:** `rst` asserted while `exit_open`=1 → `exit_open`=0 next cycle, no `car_exited`.
